// File: rtl/sw_conditioner.sv
// sw_conditioner: board switch input conditioning for the picoMIPS core.
// Each switch bit passes through a two-flop synchroniser and a per-bit
// debounce counter. The block produces clean levels, one-cycle rise/fall
// pulses and a sticky branch-flag request that the core acknowledges.
module sw_conditioner #(
   parameter int N            = 10,
   parameter int STABLE_COUNT = 16,
   parameter int FLAG_BIT     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] sw_raw,
   output logic [N-1:0] sw_clean,
   output logic [N-1:0] sw_rise,
   output logic [N-1:0] sw_fall,
   input  logic         bflag_ack,
   output logic         bflag
);

   // The counter must hold values up to STABLE_COUNT-1. Its width is sized from STABLE_COUNT+1.
   localparam int CW = $clog2(STABLE_COUNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [N-1:0]  sync1_r;
   logic [N-1:0]  sync2_r;
   logic [CW-1:0] cnt_r     [N];
   logic [CW-1:0] cnt_nxt_s [N];
   logic [N-1:0]  clean_r;
   logic [N-1:0]  clean_nxt_s;
   logic [N-1:0]  rise_r;
   logic [N-1:0]  rise_nxt_s;
   logic [N-1:0]  fall_r;
   logic [N-1:0]  fall_nxt_s;
   logic          bflag_r;
   logic          bflag_nxt_s;

   // Per-bit debounce logic. A mismatch has to persist for STABLE_COUNT evaluations before the new value is accepted.
   always_comb begin
      clean_nxt_s = clean_r;
      rise_nxt_s  = {N{1'b0}};
      fall_nxt_s  = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         if (sync2_r[i] == clean_r[i]) begin
            cnt_nxt_s[i] = CNT_ZERO;
         end else if (cnt_r[i] == CNT_LAST) begin
            clean_nxt_s[i] = sync2_r[i];
            rise_nxt_s[i]  = sync2_r[i];
            fall_nxt_s[i]  = ~sync2_r[i];
            cnt_nxt_s[i]   = CNT_ZERO;
         end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
         end
      end
   end

   // Sticky flag. A new debounced press beats a coincident ack, so that no press is lost.
   always_comb begin
      if (rise_nxt_s[FLAG_BIT]) begin
         bflag_nxt_s = 1'b1;
      end else if (bflag_ack) begin
         bflag_nxt_s = 1'b0;
      end else begin
         bflag_nxt_s = bflag_r;
      end
   end

   // Two-stage synchroniser for the asynchronous switch levels. There is no logic between the stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= {N{1'b0}};
         sync2_r <= {N{1'b0}};
      end else begin
         sync1_r <= sw_raw;
         sync2_r <= sync1_r;
      end
   end

   // Debounce counters. Reset discards any partially counted change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   // Registered clean levels, edge pulses and the branch flag. Every output comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clean_r <= {N{1'b0}};
         rise_r  <= {N{1'b0}};
         fall_r  <= {N{1'b0}};
         bflag_r <= 1'b0;
      end else begin
         clean_r <= clean_nxt_s;
         rise_r  <= rise_nxt_s;
         fall_r  <= fall_nxt_s;
         bflag_r <= bflag_nxt_s;
      end
   end

   assign sw_clean = clean_r;
   assign sw_rise  = rise_r;
   assign sw_fall  = fall_r;
   assign bflag    = bflag_r;

endmodule

// File: tb/tb_sw_conditioner.sv
// Testbench for sw_conditioner with N=10 and STABLE_COUNT=4.
// A stimulus table and a few hand-written reset sequences push expected
// output records into a scoreboard queue. The records are popped and
// compared 1 time unit after the clock edge at which they fall due.
module tb_sw_conditioner;

   localparam int N  = 10;
   localparam int SC = 4;
   localparam int FB = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] sw_raw;
   logic [N-1:0] sw_clean;
   logic [N-1:0] sw_rise;
   logic [N-1:0] sw_fall;
   logic         bflag_ack;
   logic         bflag;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [9:0] clean;
      logic [9:0] rise;
      logic [9:0] fall;
      logic       bflag;
   } exp_t;

   typedef struct {
      logic [9:0] raw;
      logic       ack;
      int         ticks;
      logic [9:0] clean;
      logic [9:0] rise;
      logic [9:0] fall;
      logic       bflag;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];

   sw_conditioner #(.N(N), .STABLE_COUNT(SC), .FLAG_BIT(FB)) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_raw    (sw_raw),
      .sw_clean  (sw_clean),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
      .bflag_ack (bflag_ack),
      .bflag     (bflag)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [9:0] c, input logic [9:0] r,
                           input logic [9:0] f, input logic b);
      exp_t e;
      e.clean = c;
      e.rise  = r;
      e.fall  = f;
      e.bflag = b;
      exp_q.push_back(e);
   endtask

   task automatic cmp1(input string tag, input string field,
                       input logic [9:0] act, input logic [9:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s.%s actual=%h expected=%h", tag, field, act, expv);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty actual=0 expected=1", tag);
      end else begin
         e = exp_q.pop_front();
         cmp1(tag, "clean", sw_clean, e.clean);
         cmp1(tag, "rise",  sw_rise,  e.rise);
         cmp1(tag, "fall",  sw_fall,  e.fall);
         cmp1(tag, "bflag", {9'd0, bflag}, {9'd0, e.bflag});
      end
   endtask

   function automatic void add(input logic [9:0] raw, input logic ack, input int ticks,
                               input logic [9:0] c, input logic [9:0] r,
                               input logic [9:0] f, input logic b);
      vec_t v;
      v.raw = raw; v.ack = ack; v.ticks = ticks;
      v.clean = c; v.rise = r; v.fall = f; v.bflag = b;
      vecs.push_back(v);
   endfunction

   initial begin
      // Table: raw, ack, ticks, then expected clean, rise, fall and bflag after those ticks.
      // The table starts from clean=3FF and bflag=1, the state left by the reset sequence.
      add(10'h3FF, 1'b1, 1, 10'h3FF, 10'h000, 10'h000, 1'b0); // ack clears the flag
      add(10'h3FF, 1'b0, 3, 10'h3FF, 10'h000, 10'h000, 1'b0); // a held switch does not set the flag again
      add(10'h000, 1'b0, 5, 10'h3FF, 10'h000, 10'h000, 1'b0);
      add(10'h000, 1'b0, 1, 10'h000, 10'h000, 10'h3FF, 1'b0);
      add(10'h000, 1'b0, 1, 10'h000, 10'h000, 10'h000, 1'b0);
      // Bounce on bit 0: the level dwells for 2 cycles at each step, then holds at 1.
      add(10'h001, 1'b0, 2, 10'h000, 10'h000, 10'h000, 1'b0);
      add(10'h000, 1'b0, 2, 10'h000, 10'h000, 10'h000, 1'b0);
      add(10'h001, 1'b0, 2, 10'h000, 10'h000, 10'h000, 1'b0);
      add(10'h000, 1'b0, 2, 10'h000, 10'h000, 10'h000, 1'b0);
      add(10'h001, 1'b0, 5, 10'h000, 10'h000, 10'h000, 1'b0);
      add(10'h001, 1'b0, 1, 10'h001, 10'h001, 10'h000, 1'b0);
      add(10'h001, 1'b0, 1, 10'h001, 10'h000, 10'h000, 1'b0);
      // Short glitch on bit 3: high for 3 samples, which is too short to be accepted.
      add(10'h009, 1'b0, 3, 10'h001, 10'h000, 10'h000, 1'b0);
      add(10'h001, 1'b0, 3, 10'h001, 10'h000, 10'h000, 1'b0);
      add(10'h001, 1'b0, 3, 10'h001, 10'h000, 10'h000, 1'b0);
      // Independent bits: bits [7:0] go to A5, then bit 1 changes 3 cycles later.
      add(10'h0A5, 1'b0, 3, 10'h001, 10'h000, 10'h000, 1'b0);
      add(10'h0A7, 1'b0, 2, 10'h001, 10'h000, 10'h000, 1'b0);
      add(10'h0A7, 1'b0, 1, 10'h0A5, 10'h0A4, 10'h000, 1'b0);
      add(10'h0A7, 1'b0, 1, 10'h0A5, 10'h000, 10'h000, 1'b0);
      add(10'h0A7, 1'b0, 1, 10'h0A5, 10'h000, 10'h000, 1'b0);
      add(10'h0A7, 1'b0, 1, 10'h0A7, 10'h002, 10'h000, 1'b0);
      add(10'h0A7, 1'b0, 1, 10'h0A7, 10'h000, 10'h000, 1'b0);
      // Flag handshake.
      add(10'h1A7, 1'b0, 5, 10'h0A7, 10'h000, 10'h000, 1'b0);
      add(10'h1A7, 1'b0, 1, 10'h1A7, 10'h100, 10'h000, 1'b1);
      add(10'h1A7, 1'b0, 4, 10'h1A7, 10'h000, 10'h000, 1'b1);
      add(10'h1A7, 1'b1, 1, 10'h1A7, 10'h000, 10'h000, 1'b0);
      add(10'h1A7, 1'b0, 3, 10'h1A7, 10'h000, 10'h000, 1'b0);
      add(10'h0A7, 1'b0, 6, 10'h0A7, 10'h000, 10'h100, 1'b0);
      add(10'h0A7, 1'b0, 1, 10'h0A7, 10'h000, 10'h000, 1'b0);
      add(10'h1A7, 1'b0, 6, 10'h1A7, 10'h100, 10'h000, 1'b1); // a second press sets the flag again
      add(10'h1A7, 1'b0, 1, 10'h1A7, 10'h000, 10'h000, 1'b1);
      add(10'h0A7, 1'b0, 6, 10'h0A7, 10'h000, 10'h100, 1'b1); // a fall does not clear the flag
      add(10'h0A7, 1'b0, 1, 10'h0A7, 10'h000, 10'h000, 1'b1);
      add(10'h1A7, 1'b0, 5, 10'h0A7, 10'h000, 10'h000, 1'b1);
      add(10'h1A7, 1'b1, 1, 10'h1A7, 10'h100, 10'h000, 1'b1); // set and ack in the same cycle: set wins
      add(10'h1A7, 1'b0, 1, 10'h1A7, 10'h000, 10'h000, 1'b1);
      add(10'h1A7, 1'b1, 1, 10'h1A7, 10'h000, 10'h000, 1'b0);

      // Reset held with all switches high.
      reset     = 1'b0;
      sw_raw    = 10'h3FF;
      bflag_ack = 1'b0;
      push_exp(10'h000, 10'h000, 10'h000, 1'b0);
      tick(3);
      pop_check("in_reset");
      reset = 1'b1;
      push_exp(10'h000, 10'h000, 10'h000, 1'b0);
      tick(5);
      pop_check("rst_e4");
      push_exp(10'h3FF, 10'h3FF, 10'h000, 1'b1);
      tick(1);
      pop_check("rst_e5");
      push_exp(10'h3FF, 10'h000, 10'h000, 1'b1);
      tick(1);
      pop_check("rst_e6");

      // Apply the vector table.
      for (int i = 0; i < vecs.size(); i++) begin
         sw_raw    = vecs[i].raw;
         bflag_ack = vecs[i].ack;
         push_exp(vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].bflag);
         tick(vecs[i].ticks);
         pop_check($sformatf("vec%0d", i));
      end
      bflag_ack = 1'b0;

      // Async reset while bit 2 is counting (clean=1A7, raw bit 2 drops to 0).
      sw_raw = 10'h1A3;
      push_exp(10'h1A7, 10'h000, 10'h000, 1'b0);
      tick(4);
      pop_check("mc_pre");
      reset = 1'b0;
      push_exp(10'h000, 10'h000, 10'h000, 1'b0);
      #1;
      pop_check("mc_async");
      push_exp(10'h000, 10'h000, 10'h000, 1'b0);
      tick(1);
      pop_check("mc_hold");
      reset = 1'b1;
      push_exp(10'h000, 10'h000, 10'h000, 1'b0);
      tick(5);
      pop_check("mc_e4");
      push_exp(10'h1A3, 10'h1A3, 10'h000, 1'b1);
      tick(1);
      pop_check("mc_e5");
      push_exp(10'h1A3, 10'h000, 10'h000, 1'b1);
      tick(1);
      pop_check("mc_e6");

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
